// File: rtl/time_set_ctrl_if.sv
// Button, live-time and edited-time signals shared between the board side and
// the time-set controller.
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hrs_1;
  logic [3:0] cur_hrs_0;
  logic [3:0] cur_min_1;
  logic [3:0] cur_min_0;
  logic [3:0] set_hrs_1;
  logic [3:0] set_hrs_0;
  logic [3:0] set_min_1;
  logic [3:0] set_min_0;
  logic       load;
  logic       hold;
  logic       blank_hrs;
  logic       blank_min;
  logic [1:0] mode;

  modport master (
    output btn_mode, btn_inc, cur_hrs_1, cur_hrs_0, cur_min_1, cur_min_0,
    input  set_hrs_1, set_hrs_0, set_min_1, set_min_0,
    input  load, hold, blank_hrs, blank_min, mode
  );

  modport slave (
    input  btn_mode, btn_inc, cur_hrs_1, cur_hrs_0, cur_min_1, cur_min_0,
    output set_hrs_1, set_hrs_0, set_min_1, set_min_0,
    output load, hold, blank_hrs, blank_min, mode
  );
endinterface

// File: rtl/time_set_ctrl.sv
// HH:MM time-set controller: debounced mode/inc buttons drive an edit FSM that
// freezes the counters, edits a BCD copy, blinks the edited digits and commits.
module time_set_ctrl #(
  parameter logic [25:0] DEBOUNCE_CYCLES = 26'd269999,
  parameter logic [25:0] BLINK_PERIOD    = 26'd13499999
) (
  input logic           sys_clk,
  input logic           sys_rst,
  time_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HRS = 2'b01,
    SET_MIN = 2'b10,
    COMMIT  = 2'b11
  } state_t;

  // Index 0 = mode button, index 1 = inc button.
  logic [1:0]  r_s1, r_s2, r_db, r_ev;
  logic [25:0] r_cnt [2];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_s1 <= '1;
      r_s2 <= '1;
      r_db <= '1;
      r_ev <= '0;
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= {bus.btn_inc, bus.btn_mode};
      r_s2 <= r_s1;
      r_ev <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s2[i] != r_db[i]) begin
          if (r_cnt[i] == DEBOUNCE_CYCLES) begin
            r_db[i]  <= r_s2[i];
            r_cnt[i] <= '0;
            // Pulse only on the accepted 1->0 flip; releases are silent.
            r_ev[i]  <= ~r_s2[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 26'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  logic w_mode_ev, w_inc_ev;
  assign w_mode_ev = r_ev[0];
  assign w_inc_ev  = r_ev[1];

  function automatic logic [7:0] inc_hrs(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd2 || u > 4'd9 || (t == 4'd2 && u >= 4'd3)) return 8'h00;
    else if (u == 4'd9) return {t + 4'd1, 4'd0};
    else return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd5 || u > 4'd9 || (t == 4'd5 && u == 4'd9)) return 8'h00;
    else if (u == 4'd9) return {t + 4'd1, 4'd0};
    else return {t, u + 4'd1};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_hrs, r_min, w_hrs_nxt, w_min_nxt;
  logic [25:0] r_bcnt, w_bcnt_nxt;
  logic        r_phase, w_phase_nxt, w_blink_clr, w_in_set;
  logic        r_load, r_hold, r_blank_hrs, r_blank_min;

  always_comb begin
    w_state_nxt = r_state;
    w_hrs_nxt   = r_hrs;
    w_min_nxt   = r_min;
    w_blink_clr = 1'b0;
    case (r_state)
      RUN: if (w_mode_ev) begin
        w_state_nxt = SET_HRS;
        w_hrs_nxt   = {bus.cur_hrs_1, bus.cur_hrs_0};
        w_min_nxt   = {bus.cur_min_1, bus.cur_min_0};
        w_blink_clr = 1'b1;
      end
      SET_HRS: if (w_mode_ev) begin
        w_state_nxt = SET_MIN;
        w_blink_clr = 1'b1;
      end else if (w_inc_ev) begin
        w_hrs_nxt   = inc_hrs(r_hrs[7:4], r_hrs[3:0]);
        w_blink_clr = 1'b1;
      end
      SET_MIN: if (w_mode_ev) begin
        w_state_nxt = COMMIT;
      end else if (w_inc_ev) begin
        w_min_nxt   = inc_min(r_min[7:4], r_min[3:0]);
        w_blink_clr = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase

    w_in_set = (w_state_nxt == SET_HRS) || (w_state_nxt == SET_MIN);
    if (!w_in_set || w_blink_clr) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (r_bcnt == BLINK_PERIOD) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = ~r_phase;
    end else begin
      w_bcnt_nxt  = r_bcnt + 26'd1;
      w_phase_nxt = r_phase;
    end
  end

  // Outputs are derived from next-state values so they line up with mode.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= RUN;
      r_hrs       <= '0;
      r_min       <= '0;
      r_bcnt      <= '0;
      r_phase     <= 1'b0;
      r_load      <= 1'b0;
      r_hold      <= 1'b0;
      r_blank_hrs <= 1'b0;
      r_blank_min <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hrs       <= w_hrs_nxt;
      r_min       <= w_min_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_phase     <= w_phase_nxt;
      r_load      <= (w_state_nxt == COMMIT);
      r_hold      <= (w_state_nxt != RUN);
      r_blank_hrs <= (w_state_nxt == SET_HRS) & w_phase_nxt;
      r_blank_min <= (w_state_nxt == SET_MIN) & w_phase_nxt;
    end
  end

  assign bus.set_hrs_1 = r_hrs[7:4];
  assign bus.set_hrs_0 = r_hrs[3:0];
  assign bus.set_min_1 = r_min[7:4];
  assign bus.set_min_0 = r_min[3:0];
  assign bus.load      = r_load;
  assign bus.hold      = r_hold;
  assign bus.blank_hrs = r_blank_hrs;
  assign bus.blank_min = r_blank_min;
  assign bus.mode      = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a scoreboard of expected observations.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_set_ctrl_if ifc ();

  time_set_ctrl #(.DEBOUNCE_CYCLES(26'd4), .BLINK_PERIOD(26'd7)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (ifc.slave)
  );

  localparam logic [21:0] M_ALL = 22'h3FFFFF;
  localparam logic [21:0] M_ST  = 22'h38FFFF;
  localparam logic [21:0] M_BH  = 22'h020000;

  typedef struct {
    string       tag;
    logic [21:0] exp;
    logic [21:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   load_cnt = 0;
  logic [15:0] load_val = '0;

  function automatic logic [21:0] obs();
    return {ifc.mode, ifc.hold, ifc.load, ifc.blank_hrs, ifc.blank_min,
            ifc.set_hrs_1, ifc.set_hrs_0, ifc.set_min_1, ifc.set_min_0};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push_state(input string tag, input logic [1:0] m, input logic [15:0] t);
    exp_t e;
    e.tag  = tag;
    e.exp  = {m, (m != 2'b00), 1'b0, 2'b00, t};
    e.mask = M_ST;
    sb.push_back(e);
  endtask

  task automatic push_raw(input string tag, input logic [21:0] v, input logic [21:0] m);
    exp_t e;
    e.tag  = tag;
    e.exp  = v;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    logic [21:0] got;
    e   = sb.pop_front();
    got = obs() & e.mask;
    n_chk++;
    assert (got === (e.exp & e.mask)) n_pass++;
    else $error("FAIL %s: got %h expected %h", e.tag, got, e.exp & e.mask);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (ifc.load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      load_val <= {ifc.set_hrs_1, ifc.set_hrs_0, ifc.set_min_1, ifc.set_min_0};
      n_chk++;
      assert (ifc.mode === 2'b11) n_pass++;
      else $error("FAIL load_in_commit: got mode %b expected 11", ifc.mode);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 mode, 1 inc, 2 both
  task automatic press(input int which, input int low);
    if (which != 1) ifc.btn_mode = 1'b0;
    if (which != 0) ifc.btn_inc  = 1'b0;
    cycles(low);
    ifc.btn_mode = 1'b1;
    ifc.btn_inc  = 1'b1;
    cycles(12);
  endtask

  task automatic set_cur(input logic [15:0] t);
    {ifc.cur_hrs_1, ifc.cur_hrs_0, ifc.cur_min_1, ifc.cur_min_0} = t;
  endtask

  initial begin
    int h;
    int k;
    bit found;
    logic [7:0] prev_h;

    ifc.btn_mode = 1'b1;
    ifc.btn_inc  = 1'b1;
    set_cur(16'h0000);
    cycles(3);
    push_raw("reset_state", 22'h0, M_ALL);
    check_next();
    rst = 1'b0;
    cycles(2);

    // 1: inc ignored in RUN, mode copies live time
    set_cur(16'h1234);
    push_state("run_inc_ignored", 2'b00, 16'h0000);
    press(1, 10); check_next();
    push_state("enter_set_hrs", 2'b01, 16'h1234);
    press(0, 10); check_next();
    check_int("no_load_yet", load_cnt, 0);
    press(0, 10);
    push_state("commit_1234", 2'b00, 16'h1234);
    press(0, 10); check_next();
    check_int("load_cnt_1", load_cnt, 1);
    check_int("load_val_1", int'(load_val), int'(16'h1234));

    // 2: hour stepping with wrap at 23
    set_cur(16'h0858);
    push_state("enter_0858", 2'b01, 16'h0858);
    press(0, 10); check_next();
    h = 8;
    for (int i = 0; i < 16; i++) begin
      h = (h + 1) % 24;
      push_state($sformatf("hrs_step%0d", i), 2'b01, {bcd(h), 8'h58});
      press(1, 10); check_next();
    end

    // 3: minute stepping, wrap without carry, invalid copy
    push_state("to_set_min", 2'b10, 16'h0058);
    press(0, 10); check_next();
    push_state("min_59", 2'b10, 16'h0059);
    press(1, 10); check_next();
    push_state("min_wrap", 2'b10, 16'h0000);
    press(1, 10); check_next();
    press(0, 10);
    check_int("load_cnt_2", load_cnt, 2);
    set_cur(16'h217A);
    press(0, 10);
    push_state("invalid_copied", 2'b10, 16'h217A);
    press(0, 10); check_next();
    push_state("invalid_min_inc", 2'b10, 16'h2100);
    press(1, 10); check_next();
    press(0, 10);
    check_int("load_cnt_3", load_cnt, 3);

    // 4: full walk commits 21:05 once
    set_cur(16'h2105);
    push_state("walk_hrs", 2'b01, 16'h2105);
    press(0, 10); check_next();
    push_state("walk_min", 2'b10, 16'h2105);
    press(0, 10); check_next();
    push_state("walk_run", 2'b00, 16'h2105);
    press(0, 10); check_next();
    check_int("load_cnt_4", load_cnt, 4);
    check_int("load_val_4", int'(load_val), int'(16'h2105));

    // 5: glitch rejected, simultaneous press: mode wins
    set_cur(16'h0530);
    push_state("enter_0530", 2'b01, 16'h0530);
    press(0, 10); check_next();
    push_state("glitch_ignored", 2'b01, 16'h0530);
    press(1, 3); check_next();
    push_state("both_mode_wins", 2'b10, 16'h0530);
    press(2, 10); check_next();

    // 6: blink timing and restart on inc
    press(0, 10);
    check_int("load_cnt_5", load_cnt, 5);
    ifc.btn_mode = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ifc.mode === 2'b01) found = 1'b1;
    end
    check_int("blink_entry_seen", int'(found), 1);
    for (k = 0; k < 24; k++) begin
      if (k == 2) ifc.btn_mode = 1'b1;
      push_raw($sformatf("blink_k%0d", k), {4'b0, 1'((k / 8) % 2), 17'b0}, M_BH);
      check_next();
      @(negedge clk);
    end
    prev_h = {ifc.set_hrs_1, ifc.set_hrs_0};
    ifc.btn_inc = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if ({ifc.set_hrs_1, ifc.set_hrs_0} !== prev_h) found = 1'b1;
    end
    check_int("blink_inc_seen", int'(found), 1);
    for (k = 0; k < 10; k++) begin
      if (k == 2) ifc.btn_inc = 1'b1;
      push_raw($sformatf("blink_restart_k%0d", k), {4'b0, 1'(k >= 8), 17'b0}, M_BH);
      check_next();
      @(negedge clk);
    end
    cycles(12);
    push_state("restart_hrs", 2'b01, 16'h0630);
    check_next();

    // reset in SET_MIN: immediate clear, no load
    push_state("pre_reset_min", 2'b10, 16'h0630);
    press(0, 10); check_next();
    #2 rst = 1'b1;
    #1;
    push_raw("reset_mid_edit", 22'h0, M_ALL);
    check_next();
    cycles(4);
    check_int("no_load_on_reset", load_cnt, 5);
    rst = 1'b0;
    cycles(3);
    push_raw("after_reset", 22'h0, M_ALL);
    check_next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
